encode_ctrl: RTL and testbench
==============================

// Module: encode_ctrl
// PURPOSE
//  Sequencer for the systematic LDPC encoder. Holds the K x (N-K) parity
//  sub-matrix P, loaded one row at a time over a config port.
//  Accepts info words on a valid/ready input and computes the check bits
//  bit-serially, one P row per cycle.
//  Emits codeword = {info_bits, check_bits} on a valid/ready output with a
//  one-entry holding register. Sits between the info-word source and the channel/FIFO.
// PARAMETERS
//  N      6   codeword length (bits)
//  K      3   info length (bits); N-K check bits; requires 1 <= K < N
//  CNT_W  16  width of the encoded-word counter
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  cfg_wr     in   1               write one row of P
//  cfg_row    in   $clog2(K)+1     row index j, valid range 0..K-1
//  cfg_data   in   N-K             P[j][N-K-1:0]; bit i = P[j][i]
//  cfg_done   out  1               all K rows written since reset
//  cfg_err    out  1               1-cycle pulse: config write rejected
//  in_valid   in   1               info word offered
//  in_ready   out  1               controller can accept info word
//  info_bits  in   K               info word; bit j selects P row j
//  out_valid  out  1               codeword available
//  out_ready  in   1               downstream accepts codeword
//  codeword   out  N               {info_bits, check_bits}
//  busy       out  1               state is CALC or HOLD
//  word_cnt   out  CNT_W           codewords delivered; wraps to 0
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=UNCFG, row mask=0, P=0.
//   Outputs after reset: cfg_done=0, cfg_err=0, in_ready=0, out_valid=0,
//   codeword=0, busy=0, word_cnt=0. rst overrides all other inputs.
//  Transfer occurs when valid & ready are both high at a posedge.
//  States:
//   UNCFG: in_ready=0.
//    - cfg_wr with cfg_row<K: writes P row, sets that mask bit.
//    - Goes to IDLE on the cycle after the last missing row is written;
//      cfg_done=1 from then until reset.
//   IDLE: in_ready=1.
//    - cfg_wr with cfg_row<K rewrites that row (live update).
//    - On input transfer: latch info_bits, clear check accumulator, j=0,
//      go to CALC.
//    - A simultaneous cfg_wr and input transfer are both taken. The latched
//      word uses the NEW row value.
//   CALC: in_ready=0. Lasts exactly K cycles.
//    - Each cycle: acc ^= info[j] ? P[j] : 0; then j++.
//    - After j=K-1: codeword <= {info, acc ^ term_K-1}; out_valid=1;
//      go to HOLD.
//   HOLD: out_valid=1; codeword stable until out_ready=1.
//    - On output transfer: word_cnt++ (mod 2^CNT_W), out_valid=0,
//      go to IDLE.
//  Latency: input transfer at edge t -> out_valid high after edge t+K.
//   The next input is accepted no earlier than 1 cycle after the output
//   transfer (no overlap). Throughput: 1 word per K+2 cycles.
//  cfg_err pulses on:
//   - cfg_wr with cfg_row>=K, in any state (write dropped);
//   - cfg_wr in CALC or HOLD (write dropped; P is frozen mid-encode).
//  in_valid while in_ready=0 is ignored, not buffered; the source must hold
//   the word. info_bits are sampled only at the transfer edge.
//  out_ready while out_valid=0: no effect. codeword keeps its last value
//   outside HOLD.
//  rst asserted mid-CALC/HOLD: pending word is discarded, state=UNCFG,
//   P is cleared; config must be reloaded before the next word.
//  All-zero info word: codeword=0, still takes full K-cycle latency.
// TESTING  (N=6, K=3; P rows r0=3'b011, r1=3'b101, r2=3'b110)
//  1. Reset, then in_valid=1 with no config -> in_ready stays 0 for 20
//     cycles. Write r0,r1,r2 -> cfg_done=1, in_ready=1 the next cycle.
//  2. info=3'b010 -> out_valid exactly 3 cycles after the accept edge,
//     codeword=6'b010101. Also info=3'b111 -> 6'b111000; info=3'b011 -> 6'b011110.
//  3. out_ready held 0 for 10 cycles -> codeword, out_valid stable and
//     in_ready=0. Raise out_ready -> word_cnt increments by 1, in_ready=1
//     the next cycle.
//  4. cfg_wr with cfg_row=3 -> cfg_err pulses 1 cycle, P unchanged.
//     cfg_wr during CALC -> cfg_err pulses and the result uses the old row.
//     cfg_wr r1=3'b111 in IDLE together with accepting info=3'b010 -> codeword=6'b010111.
//  5. Assert rst during CALC -> out_valid never rises; after release,
//     state=UNCFG and word_cnt=0.
//  6. Back-to-back stream of 1000 random words, random out_ready -> every
//     codeword matches a reference GF(2) model. word_cnt=1000 (mod 2^16);
//     test wrap by forcing the counter to 16'hFFFF, then one word -> 0.

Source files
------------

// File: rtl/encode_ctrl.sv
// Sequencer for a systematic LDPC encoder: holds the K x (N-K) parity sub-matrix,
// accumulates check bits one P row per cycle and presents {info, check} downstream.
module encode_ctrl #(
  parameter int unsigned N     = 6,
  parameter int unsigned K     = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [$clog2(K):0]   cfg_row,
  input  logic [N-K-1:0]       cfg_data,
  output logic                 cfg_done,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         info_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         codeword,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int unsigned M  = N - K;
  localparam int unsigned RW = $clog2(K) + 1;
  localparam int unsigned JW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] StUncfg = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StCalc  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  localparam logic [RW-1:0] RowLim = RW'(K);
  localparam logic [JW-1:0] JLast  = JW'(K - 1);

  logic [1:0]            state_q, state_d;
  logic [K-1:0]          mask_q, mask_d;
  logic [K-1:0][M-1:0]   p_q, p_d;
  logic [K-1:0]          info_q, info_d;
  logic [M-1:0]          acc_q, acc_d;
  logic [JW-1:0]         j_q, j_d;
  logic [N-1:0]          cw_q, cw_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  cfg_take;
  logic [M-1:0]          term;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    p_d     = p_q;
    info_d  = info_q;
    acc_d   = acc_q;
    j_d     = j_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;

    // P is frozen while a word is in flight; out-of-range rows are always dropped.
    cfg_take = cfg_wr && (cfg_row < RowLim) && ((state_q == StUncfg) || (state_q == StIdle));
    err_d    = cfg_wr && !cfg_take;
    if (cfg_take) begin
      p_d[cfg_row[JW-1:0]]    = cfg_data;
      mask_d[cfg_row[JW-1:0]] = 1'b1;
    end

    term = info_q[j_q] ? p_q[j_q] : '0;

    case (state_q)
      StUncfg: begin
        if (&mask_d) state_d = StIdle;
      end
      StIdle: begin
        if (in_valid) begin
          info_d  = info_bits;
          acc_d   = '0;
          j_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_q ^ term;
        j_d   = j_q + 1'b1;
        if (j_q == JLast) begin
          cw_d    = {info_q, acc_q ^ term};
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StUncfg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StUncfg;
      mask_q  <= '0;
      p_q     <= '0;
      info_q  <= '0;
      acc_q   <= '0;
      j_q     <= '0;
      cw_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      p_q     <= p_d;
      info_q  <= info_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cfg_done  = &mask_q;
  assign cfg_err   = err_q;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StCalc) || (state_q == StHold);
  assign codeword  = cw_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_encode_ctrl.sv
// Scoreboard bench for encode_ctrl: a GF(2) reference model predicts every codeword
// at the input handshake; a negedge monitor checks it at the output handshake.
module tb_encode_ctrl;

  localparam int N = 6;
  localparam int K = 3;
  localparam int M = N - K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_wr, in_valid, out_ready;
  logic [2:0]    cfg_row;
  logic [M-1:0]  cfg_data;
  logic [K-1:0]  info_bits;
  logic          cfg_done, cfg_err, in_ready, out_valid, busy;
  logic [N-1:0]  codeword;
  logic [15:0]   word_cnt;

  // Narrow-counter copy sharing all inputs, used to observe counter wrap.
  logic          s_cfg_done, s_cfg_err, s_in_ready, s_out_valid, s_busy;
  logic [N-1:0]  s_codeword;
  logic [1:0]    s_word_cnt;

  encode_ctrl #(.N(N), .K(K), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .info_bits(info_bits), .out_valid(out_valid), .out_ready(out_ready),
    .codeword(codeword), .busy(busy), .word_cnt(word_cnt)
  );

  encode_ctrl #(.N(N), .K(K), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_done(s_cfg_done), .cfg_err(s_cfg_err), .in_valid(in_valid), .in_ready(s_in_ready),
    .info_bits(info_bits), .out_valid(s_out_valid), .out_ready(out_ready),
    .codeword(s_codeword), .busy(s_busy), .word_cnt(s_word_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [M-1:0] mp [K];
  logic [N-1:0] exp_q [$];
  logic [N-1:0] exp_v;
  int n_in = 0;
  int n_out = 0;
  int exp_cnt = 0;

  function automatic logic [N-1:0] ref_cw(input logic [K-1:0] info);
    logic [M-1:0] a;
    a = '0;
    for (int j = 0; j < K; j++) if (info[j]) a ^= mp[j];
    return {info, a};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_cw(info_bits));
        n_in++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: got codeword=%b, no word expected", codeword);
        end else begin
          exp_v = exp_q.pop_front();
          if (codeword !== exp_v) begin
            bad++;
            $display("FAIL sb_codeword: got %b expected %b", codeword, exp_v);
          end
        end
        n_out++;
        exp_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int j = 0; j < K; j++) mp[j] = '0;
  endtask

  task automatic write_row(input int row, input logic [M-1:0] d, input logic exp_err);
    cfg_wr = 1'b1;
    cfg_row = 3'(row);
    cfg_data = d;
    if (!exp_err) mp[row] = d;
    tick;
    cfg_wr = 1'b0;
    total++;
    if (cfg_err !== exp_err) begin
      bad++;
      $display("FAIL cfg_err_row%0d: got %b expected %b", row, cfg_err, exp_err);
    end
  endtask

  task automatic load_cfg;
    write_row(0, 3'b011, 1'b0);
    write_row(1, 3'b101, 1'b0);
    write_row(2, 3'b110, 1'b0);
  endtask

  task automatic accept(input logic [K-1:0] info);
    in_valid = 1'b1;
    info_bits = info;
    for (int i = 0; i < 50 && !in_ready; i++) tick;
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat);
    logic early;
    early = 1'b0;
    for (int c = 1; c < lat; c++) begin
      tick;
      if (out_valid) early = 1'b1;
    end
    tick;
    total++;
    if (early || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency: early=%b out_valid=%b expected early=0 out_valid=1",
               early, out_valid);
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic check_cw(input string name, input logic [N-1:0] want);
    total++;
    if (codeword !== want) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, codeword, want);
    end
  endtask

  task automatic test_reset;
    int hits;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    clear_model();
    total++;
    if ({cfg_done, cfg_err, in_ready, out_valid, busy, codeword, word_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_state: got done=%b err=%b rdy=%b ov=%b busy=%b cw=%b cnt=%0d expected all 0",
               cfg_done, cfg_err, in_ready, out_valid, busy, codeword, word_cnt);
    end
    hits = 0;
    in_valid = 1'b1;
    info_bits = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (in_ready) hits++;
    end
    in_valid = 1'b0;
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL unconfig_ready: in_ready high %0d cycles expected 0", hits);
    end
  endtask

  task automatic test_config;
    write_row(0, 3'b011, 1'b0);
    write_row(1, 3'b101, 1'b0);
    total++;
    if (cfg_done !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL partial_cfg: done=%b rdy=%b expected 0 0", cfg_done, in_ready);
    end
    write_row(2, 3'b110, 1'b0);
    total++;
    if (cfg_done !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_complete: done=%b rdy=%b expected 1 1", cfg_done, in_ready);
    end
  endtask

  task automatic test_encode;
    logic [K-1:0] infos [3];
    logic [N-1:0] cws [3];
    infos = '{3'b010, 3'b111, 3'b011};
    cws   = '{6'b010101, 6'b111000, 6'b011110};
    for (int i = 0; i < 3; i++) begin
      accept(infos[i]);
      wait_out(K);
      check_cw($sformatf("encode_%b", infos[i]), cws[i]);
      drain();
    end
    total++;
    if (word_cnt !== 16'd3) begin
      bad++;
      $display("FAIL encode_cnt: got %0d expected 3", word_cnt);
    end
  endtask

  task automatic test_hold;
    int unstable;
    int cnt0;
    accept(3'b111);
    wait_out(K);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!out_valid || in_ready || codeword !== 6'b111000) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL hold_stable: %0d unstable cycles expected 0", unstable);
    end
    cnt0 = exp_cnt;
    drain();
    total++;
    if (word_cnt !== 16'(cnt0 + 1) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: cnt=%0d rdy=%b ov=%b expected cnt=%0d rdy=1 ov=0",
               word_cnt, in_ready, out_valid, cnt0 + 1);
    end
  endtask

  task automatic test_cfg_err;
    write_row(3, 3'b111, 1'b1);
    accept(3'b010);
    wait_out(K);
    check_cw("bad_row_unchanged", 6'b010101);
    drain();
    accept(3'b010);
    write_row(1, 3'b111, 1'b1);
    wait_out(K - 1);
    check_cw("calc_write_dropped", 6'b010101);
    drain();
    // Simultaneous row update and accept: the word must see the new row.
    cfg_wr = 1'b1;
    cfg_row = 3'd1;
    cfg_data = 3'b111;
    mp[1] = 3'b111;
    in_valid = 1'b1;
    info_bits = 3'b010;
    tick;
    cfg_wr = 1'b0;
    in_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL simul_accept: err=%b busy=%b expected 0 1", cfg_err, busy);
    end
    wait_out(K);
    check_cw("simul_new_row", 6'b010111);
    drain();
    write_row(1, 3'b101, 1'b0);
  endtask

  task automatic test_reset_mid;
    int rises;
    accept(3'b110);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_model();
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid) rises++;
    end
    total++;
    if (rises != 0) begin
      bad++;
      $display("FAIL reset_mid_ov: out_valid high %0d cycles expected 0", rises);
    end
    total++;
    if ({in_ready, cfg_done, busy, word_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_mid_state: rdy=%b done=%b busy=%b cnt=%0d expected all 0",
               in_ready, cfg_done, busy, word_cnt);
    end
    load_cfg();
  endtask

  task automatic test_back_to_back;
    int start_in, start_out, last_in, cnt0, cyc, rem;
    int unsigned rnd;
    cnt0 = exp_cnt;
    start_in = n_in;
    start_out = n_out;
    last_in = n_in;
    cyc = 0;
    rnd = $urandom;
    info_bits = rnd[K-1:0];
    in_valid = 1'b1;
    while ((n_out - start_out) < 1000 && cyc < 40000) begin
      rnd = $urandom;
      out_ready = rnd[0];
      tick;
      cyc++;
      if (n_in != last_in) begin
        last_in = n_in;
        if ((n_in - start_in) < 1000) begin
          rnd = $urandom;
          info_bits = rnd[K-1:0];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if ((n_out - start_out) != 1000) begin
      bad++;
      $display("FAIL stream_timeout: delivered %0d expected 1000", n_out - start_out);
    end
    total++;
    if (word_cnt !== 16'(cnt0 + 1000) || s_word_cnt !== 2'(cnt0 + 1000)) begin
      bad++;
      $display("FAIL stream_cnt: got %0d/%0d expected %0d/%0d", word_cnt, s_word_cnt,
               16'(cnt0 + 1000), 2'(cnt0 + 1000));
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stream_leftover: %0d words expected 0", exp_q.size());
    end
    // Narrow counter: walk up to 3, then one more word must wrap it to 0.
    rem = (3 - (exp_cnt % 4)) % 4;
    for (int i = 0; i < rem; i++) begin
      accept(3'b101);
      wait_out(K);
      drain();
    end
    total++;
    if (s_word_cnt !== 2'd3) begin
      bad++;
      $display("FAIL wrap_pre: got %0d expected 3", s_word_cnt);
    end
    accept(3'b100);
    wait_out(K);
    drain();
    total++;
    if (s_word_cnt !== 2'd0 || word_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL wrap: got %0d/%0d expected 0/%0d", s_word_cnt, word_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_row = '0;
    cfg_data = '0;
    in_valid = 1'b0;
    info_bits = '0;
    out_ready = 1'b0;
    test_reset();
    test_config();
    test_encode();
    test_hold();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
